// File: rtl/branch_pred_unit_if.sv
// Bundle of IF-side prediction and EX-side resolution signals for the
// branch prediction unit. The slave modport is the predictor itself; the
// master modport is the pipeline that feeds it and consumes its decisions.
interface branch_pred_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  // Fetch-side prediction request/response
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;

  // Execute-side resolution inputs
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [3:0]       ex_branch;
  logic             ex_less;
  logic             ex_zero;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;

  // Execute-side resolution outputs
  logic             pc_src_a;
  logic             pc_src_b;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;

  // Performance counters
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport slave (
    input  if_pc,
    output pred_taken,
    output pred_target,
    input  ex_valid,
    input  ex_pc,
    input  ex_branch,
    input  ex_less,
    input  ex_zero,
    input  ex_target,
    input  ex_pred_taken,
    input  ex_pred_target,
    output pc_src_a,
    output pc_src_b,
    output mispredict,
    output redirect_pc,
    output br_count,
    output mispred_count
  );

  modport master (
    output if_pc,
    input  pred_taken,
    input  pred_target,
    output ex_valid,
    output ex_pc,
    output ex_branch,
    output ex_less,
    output ex_zero,
    output ex_target,
    output ex_pred_taken,
    output ex_pred_target,
    input  pc_src_a,
    input  pc_src_b,
    input  mispredict,
    input  redirect_pc,
    input  br_count,
    input  mispred_count
  );

endinterface

// File: rtl/branch_pred_unit.sv
// Branch resolution and prediction for the RV core.
// EX resolves branches/jumps from the 4-bit branch code and the ALU flags,
// driving the legacy pc_src_a/pc_src_b selects and a mispredict redirect.
// A direct-mapped BTB with 2-bit saturating counters supplies IF with a
// predicted target; it learns from every resolved branch or jump in EX.
// BTB_DEPTH must be a power of two and at least 4.
module branch_pred_unit #(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_pred_unit_if.slave  bus
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [3:0] BR_JAL  = 4'b0001;
  localparam logic [3:0] BR_JALR = 4'b0010;
  localparam logic [3:0] BR_BEQ  = 4'b0100;
  localparam logic [3:0] BR_BNE  = 4'b0101;
  localparam logic [3:0] BR_BLT  = 4'b0110;
  localparam logic [3:0] BR_BGE  = 4'b0111;

  // BTB storage; only the valid bits are reset, the rest is qualified by them
  logic [BTB_DEPTH-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      r_target [BTB_DEPTH];
  logic [1:0]           r_ctr    [BTB_DEPTH];

  logic [CNT_W-1:0]     r_brCount;
  logic [CNT_W-1:0]     r_mispredCount;

  logic [IDX_W-1:0]     w_ifIdx;
  logic [TAG_W-1:0]     w_ifTag;
  logic                 w_ifHit;
  logic                 w_predTaken;

  logic [IDX_W-1:0]     w_exIdx;
  logic [TAG_W-1:0]     w_exTag;
  logic                 w_exHit;

  logic                 w_isJump;
  logic                 w_isJalr;
  logic                 w_isBranch;
  logic                 w_rawTaken;
  logic                 w_taken;
  logic                 w_mispredict;
  logic                 w_update;
  logic [1:0]           w_ctrNext;

  // The two low PC bits never take part in indexing or tagging
  logic                 w_unused;
  assign w_unused = ^bus.if_pc[1:0];

  assign w_ifIdx = bus.if_pc[IDX_W+1:2];
  assign w_ifTag = bus.if_pc[XLEN-1:IDX_W+2];
  assign w_exIdx = bus.ex_pc[IDX_W+1:2];
  assign w_exTag = bus.ex_pc[XLEN-1:IDX_W+2];

  // Fetch-side lookup reads only registered table state, so a write made
  // this cycle becomes visible to IF on the following cycle
  always_comb begin
    w_ifHit     = r_valid[w_ifIdx] && (r_tag[w_ifIdx] == w_ifTag);
    w_predTaken = w_ifHit && r_ctr[w_ifIdx][1];
    w_exHit     = r_valid[w_exIdx] && (r_tag[w_exIdx] == w_exTag);
  end

  assign bus.pred_taken  = w_predTaken;
  assign bus.pred_target = w_predTaken ? r_target[w_ifIdx] : '0;

  // Decode the branch code into a raw taken decision; unknown codes act as
  // "no branch" so they neither redirect nor train the table
  always_comb begin
    w_isJump   = 1'b0;
    w_isJalr   = 1'b0;
    w_isBranch = 1'b1;
    w_rawTaken = 1'b0;
    case (bus.ex_branch)
      BR_JAL: begin
        w_isJump   = 1'b1;
        w_rawTaken = 1'b1;
      end
      BR_JALR: begin
        w_isJump   = 1'b1;
        w_isJalr   = 1'b1;
        w_rawTaken = 1'b1;
      end
      BR_BEQ:  w_rawTaken = bus.ex_zero;
      BR_BNE:  w_rawTaken = ~bus.ex_zero;
      BR_BLT:  w_rawTaken = bus.ex_less;
      BR_BGE:  w_rawTaken = ~bus.ex_less;
      default: w_isBranch = 1'b0;
    endcase
  end

  assign w_taken  = bus.ex_valid && w_rawTaken;
  assign w_update = bus.ex_valid && w_isBranch;

  // A prediction is wrong if the direction differs, or if both agree on
  // taken but the carried target is not the computed one
  assign w_mispredict = bus.ex_valid &&
                        ((w_taken != bus.ex_pred_taken) ||
                         (w_taken && (bus.ex_target != bus.ex_pred_target)));

  assign bus.pc_src_a    = w_taken;
  assign bus.pc_src_b    = bus.ex_valid && w_isJalr;
  assign bus.mispredict  = w_mispredict;
  assign bus.redirect_pc = w_taken ? bus.ex_target : (bus.ex_pc + XLEN'(4));

  // Next counter value for an entry that hits at the EX index: jumps are
  // pinned strongly taken, conditionals saturate in either direction
  always_comb begin
    w_ctrNext = r_ctr[w_exIdx];
    if (w_isJump) begin
      w_ctrNext = 2'b11;
    end else if (w_rawTaken) begin
      if (r_ctr[w_exIdx] != 2'b11) w_ctrNext = r_ctr[w_exIdx] + 2'd1;
    end else begin
      if (r_ctr[w_exIdx] != 2'b00) w_ctrNext = r_ctr[w_exIdx] - 2'd1;
    end
  end

  // Table training and performance counting; reset overrides any update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid        <= '0;
      r_brCount      <= '0;
      r_mispredCount <= '0;
    end else begin
      if (w_update) begin
        if (w_exHit) begin
          r_ctr[w_exIdx] <= w_ctrNext;
          if (w_rawTaken) r_target[w_exIdx] <= bus.ex_target;
        end else if (w_rawTaken) begin
          r_valid[w_exIdx]  <= 1'b1;
          r_tag[w_exIdx]    <= w_exTag;
          r_target[w_exIdx] <= bus.ex_target;
          r_ctr[w_exIdx]    <= w_isJump ? 2'b11 : 2'b10;
        end
        r_brCount <= r_brCount + CNT_W'(1);
      end
      if (w_mispredict) r_mispredCount <= r_mispredCount + CNT_W'(1);
    end
  end

  assign bus.br_count      = r_brCount;
  assign bus.mispred_count = r_mispredCount;

endmodule
